axi_ahb_rw_scheduler: RTL and testbench



---
 rtl/axi_ahb_rw_scheduler_if.sv | 32 +++
 rtl/axi_ahb_rw_scheduler.sv | 146 ++++++++++++++
 tb/tb_axi_ahb_rw_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_ahb_rw_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_ahb_rw_scheduler_if                                    |
// | Brief    : Request/grant bundle between bridge FIFOs and AHB scheduler|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface axi_ahb_rw_scheduler_if;
    logic       wr_req;
    logic [3:0] wr_len;
    logic       rd_req;
    logic [3:0] rd_len;
    logic       beat_done;
    logic       abort;
    logic       grant_wr;
    logic       grant_rd;
    logic [3:0] beat_cnt;
    logic       burst_last;
    logic       wr_pop;
    logic       rd_pop;
    logic       busy;

    modport master (
        output wr_req, wr_len, rd_req, rd_len, beat_done, abort,
        input  grant_wr, grant_rd, beat_cnt, burst_last, wr_pop, rd_pop, busy
    );

    modport slave (
        input  wr_req, wr_len, rd_req, rd_len, beat_done, abort,
        output grant_wr, grant_rd, beat_cnt, burst_last, wr_pop, rd_pop, busy
    );
endinterface
`default_nettype wire

// File: rtl/axi_ahb_rw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axi_ahb_rw_scheduler                                       |
// | Brief    : Burst-granular round-robin owner of the bridge AHB port    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module axi_ahb_rw_scheduler #(
    parameter int PRIORITY_WRITE = 1,
    parameter int TURN_CYCLES    = 1
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    axi_ahb_rw_scheduler_if.slave        bus
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WR_BURST = 3'd1;
    localparam logic [2:0] c_RD_BURST = 3'd2;
    localparam logic [2:0] c_TURN     = 3'd3;
    localparam logic [2:0] c_WR_LOAD  = 3'd4;
    localparam logic [2:0] c_RD_LOAD  = 3'd5;

    localparam logic [1:0] c_TURN_LOAD    = 2'(TURN_CYCLES);
    // last_dir is 1 for write; reset so the first tie lands on the preferred side
    localparam logic       c_LAST_DIR_RST = (PRIORITY_WRITE == 0);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_last_dir;
    logic [3:0] r_len;
    logic [3:0] r_beat_cnt;
    logic [1:0] r_turn_cnt;

    logic w_in_wr;
    logic w_in_rd;
    logic w_in_burst;
    logic w_last;
    logic w_end;

    assign w_in_wr    = (r_state == c_WR_BURST);
    assign w_in_rd    = (r_state == c_RD_BURST);
    assign w_in_burst = w_in_wr || w_in_rd;
    assign w_last     = w_in_burst && (r_beat_cnt == r_len);
    assign w_end      = w_in_burst && (bus.abort || (bus.beat_done && w_last));

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.wr_req && bus.rd_req) begin
                    w_state_nxt = r_last_dir ? c_RD_BURST : c_WR_BURST;
                end else if (bus.wr_req) begin
                    w_state_nxt = c_WR_BURST;
                end else if (bus.rd_req) begin
                    w_state_nxt = c_RD_BURST;
                end
            end
            c_WR_BURST: begin
                if (w_end) begin
                    if (bus.rd_req) begin
                        w_state_nxt = (TURN_CYCLES == 0) ? c_RD_BURST : c_TURN;
                    end else if (bus.wr_req) begin
                        w_state_nxt = c_WR_LOAD;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            c_RD_BURST: begin
                if (w_end) begin
                    if (bus.wr_req) begin
                        w_state_nxt = (TURN_CYCLES == 0) ? c_WR_BURST : c_TURN;
                    end else if (bus.rd_req) begin
                        w_state_nxt = c_RD_LOAD;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            // the popped FIFO head has settled by now, so its len is latched on exit
            c_WR_LOAD: w_state_nxt = bus.wr_req ? c_WR_BURST : c_IDLE;
            c_RD_LOAD: w_state_nxt = bus.rd_req ? c_RD_BURST : c_IDLE;
            c_TURN: begin
                if (r_turn_cnt <= 2'd1) begin
                    if (!r_last_dir) begin
                        w_state_nxt = bus.wr_req ? c_WR_BURST : c_IDLE;
                    end else begin
                        w_state_nxt = bus.rd_req ? c_RD_BURST : c_IDLE;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_last_dir <= c_LAST_DIR_RST;
            r_len      <= 4'd0;
            r_beat_cnt <= 4'd0;
            r_turn_cnt <= 2'd0;
        end else begin
            if (w_end) begin
                r_last_dir <= w_in_wr;
            end

            if ((w_state_nxt == c_WR_BURST) && (r_state != c_WR_BURST)) begin
                r_len <= bus.wr_len;
            end else if ((w_state_nxt == c_RD_BURST) && (r_state != c_RD_BURST)) begin
                r_len <= bus.rd_len;
            end

            if (!w_in_burst || w_end) begin
                r_beat_cnt <= 4'd0;
            end else if (bus.beat_done && (r_beat_cnt != r_len)) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end

            if (w_end && (w_state_nxt == c_TURN)) begin
                r_turn_cnt <= c_TURN_LOAD;
            end else if ((r_state == c_TURN) && (r_turn_cnt != 2'd0)) begin
                r_turn_cnt <= r_turn_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        bus.grant_wr   = (r_state == c_WR_BURST) || (r_state == c_WR_LOAD);
        bus.grant_rd   = (r_state == c_RD_BURST) || (r_state == c_RD_LOAD);
        bus.beat_cnt   = r_beat_cnt;
        bus.burst_last = w_last;
        bus.wr_pop     = w_end && w_in_wr;
        bus.rd_pop     = w_end && w_in_rd;
        bus.busy       = (r_state != c_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ahb_rw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_axi_ahb_rw_scheduler                                    |
// | Brief    : Cycle-level scoreboard bench for axi_ahb_rw_scheduler      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axi_ahb_rw_scheduler;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    logic a_clk    = 1'b0;
    logic a_resetn = 1'b0;

    axi_ahb_rw_scheduler_if bus ();

    axi_ahb_rw_scheduler #(
        .PRIORITY_WRITE (1),
        .TURN_CYCLES    (1)
    ) u_dut (
        .a_clk    (a_clk),
        .a_resetn (a_resetn),
        .bus      (bus)
    );

    always #5 a_clk = ~a_clk;

    exp_t  sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    string scen   = "init";
    int    step   = 0;

    task automatic chk(input string tag, input logic [9:0] act, input logic [9:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got gw,gr,cnt,last,wp,rp,busy=%b required %b", tag, act, exp);
        end
    endtask

    // {grant_wr, grant_rd, beat_cnt, burst_last, wr_pop, rd_pop, busy}
    function automatic logic [9:0] E(input logic gw, input logic gr, input logic [3:0] cnt,
                                     input logic last, input logic wp, input logic rp,
                                     input logic bsy);
        return {gw, gr, cnt, last, wp, rp, bsy};
    endfunction

    always @(negedge a_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, {bus.grant_wr, bus.grant_rd, bus.beat_cnt, bus.burst_last,
                        bus.wr_pop, bus.rd_pop, bus.busy}, e.v);
        end
    end

    task automatic cyc(input logic wr, input logic [3:0] wl, input logic rd,
                       input logic [3:0] rl, input logic bd, input logic ab,
                       input logic [9:0] e);
        exp_t x;
        bus.wr_req    = wr;
        bus.wr_len    = wl;
        bus.rd_req    = rd;
        bus.rd_len    = rl;
        bus.beat_done = bd;
        bus.abort     = ab;
        x.tag = $sformatf("%s_c%0d", scen, step);
        x.v   = e;
        sb.push_back(x);
        step++;
        @(posedge a_clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        scen     = name;
        step     = 0;
        a_resetn = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));
        a_resetn = 1'b1;
    endtask

    initial begin
        bus.wr_req = 0; bus.wr_len = 0; bus.rd_req = 0; bus.rd_len = 0;
        bus.beat_done = 0; bus.abort = 0;
        @(posedge a_clk);
        #1;

        // single write len 3 with one stalled beat
        do_reset("rst_wr");
        scen = "wr"; step = 0;
        cyc(1, 3, 0, 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        cyc(1, 3, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 0, 1));
        cyc(1, 3, 0, 0, 0, 0, E(1, 0, 1, 0, 0, 0, 1));
        cyc(1, 3, 0, 0, 1, 0, E(1, 0, 1, 0, 0, 0, 1));
        cyc(1, 3, 0, 0, 1, 0, E(1, 0, 2, 0, 0, 0, 1));
        cyc(0, 3, 0, 0, 1, 0, E(1, 0, 3, 1, 1, 0, 1));
        cyc(0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));

        // tie after reset: write first, TURN between, alternating; stray inputs in TURN/IDLE
        do_reset("rst_tie");
        scen = "tie"; step = 0;
        cyc(1, 0, 1, 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        cyc(1, 0, 1, 0, 1, 0, E(1, 0, 0, 1, 1, 0, 1));
        cyc(1, 0, 1, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 1));
        cyc(1, 0, 1, 0, 1, 0, E(0, 1, 0, 1, 0, 1, 1));
        cyc(1, 0, 1, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 1));
        cyc(1, 0, 1, 0, 1, 0, E(1, 0, 0, 1, 1, 0, 1));
        cyc(0, 0, 0, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 1));
        cyc(0, 0, 0, 0, 1, 1, E(0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));

        // back-to-back reads len 1 then 2 with LOAD cycle
        do_reset("rst_b2b");
        scen = "b2b"; step = 0;
        cyc(0, 0, 1, 1, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 1, 1, 1, 0, E(0, 1, 0, 0, 0, 0, 1));
        cyc(0, 0, 1, 1, 1, 0, E(0, 1, 1, 1, 0, 1, 1));
        cyc(0, 0, 1, 2, 1, 1, E(0, 1, 0, 0, 0, 0, 1));
        cyc(0, 0, 1, 2, 1, 0, E(0, 1, 0, 0, 0, 0, 1));
        cyc(0, 0, 1, 2, 1, 0, E(0, 1, 1, 0, 0, 0, 1));
        cyc(0, 0, 0, 2, 1, 0, E(0, 1, 2, 1, 0, 1, 1));
        cyc(0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));

        // abort coinciding with beat_done at beat 2 of a len-7 write
        do_reset("rst_abt");
        scen = "abt"; step = 0;
        cyc(1, 7, 0, 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        cyc(1, 7, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 0, 1));
        cyc(1, 7, 0, 0, 1, 0, E(1, 0, 1, 0, 0, 0, 1));
        cyc(0, 7, 0, 0, 1, 1, E(1, 0, 2, 0, 1, 0, 1));
        cyc(0, 0, 0, 0, 1, 0, E(0, 0, 0, 0, 0, 0, 0));

        // reset asserted at beat 3 of a len-5 read, then replay from beat 0
        do_reset("rst_mid");
        scen = "mid"; step = 0;
        cyc(0, 0, 1, 5, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 0, 0, 0, 0, 1));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 1, 0, 0, 0, 1));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 2, 0, 0, 0, 1));
        a_resetn = 1'b0;
        cyc(0, 0, 1, 5, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        a_resetn = 1'b1;
        cyc(0, 0, 1, 5, 1, 0, E(0, 0, 0, 0, 0, 0, 0));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 0, 0, 0, 0, 1));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 1, 0, 0, 0, 1));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 2, 0, 0, 0, 1));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 3, 0, 0, 0, 1));
        cyc(0, 0, 1, 5, 1, 0, E(0, 1, 4, 0, 0, 0, 1));
        cyc(0, 0, 0, 5, 1, 0, E(0, 1, 5, 1, 0, 1, 1));
        cyc(0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0));

        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
